// File: rtl/key_evt_pkg.sv
// Shared defaults and types for the key event arbiter slice.
package key_evt_pkg;
  localparam int unsigned N_BTN_DEF      = 4;
  localparam int unsigned FIFO_DEPTH_DEF = 4;
  localparam int unsigned ID_W_DEF       = 2;
  localparam int unsigned DROP_W_DEF     = 8;

  typedef logic [ID_W_DEF-1:0] evt_id_t;
endpackage

// File: rtl/key_evt_fifo.sv
// Synchronous event FIFO with registered head, async active-high reset.
module key_evt_fifo
  import key_evt_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned W     = ID_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_data  = o_empty ? '0 : r_mem[r_rd];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/key_event_arbiter.sv
// Latches button presses, round-robin grants one per cycle into an event FIFO,
// and counts presses that arrive while their latch is still occupied.
module key_event_arbiter
  import key_evt_pkg::*;
#(
  parameter int unsigned N_BTN      = N_BTN_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned ID_W       = ID_W_DEF,
  parameter int unsigned DROP_W     = DROP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [N_BTN-1:0]  btn_pulse,
  output logic              evt_valid,
  output logic [ID_W-1:0]   evt_id,
  input  logic              evt_ready,
  output logic [N_BTN-1:0]  pending,
  output logic              fifo_full,
  output logic [DROP_W-1:0] drop_cnt
);
  logic [N_BTN-1:0]  r_pending;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [DROP_W-1:0] r_drop_cnt;
  logic [N_BTN-1:0]  w_cap;
  logic [N_BTN-1:0]  w_gnt_vec;
  logic [N_BTN-1:0]  w_drop_vec;
  logic [ID_W-1:0]   w_gnt_id;
  logic              w_gnt;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [DROP_W:0]   w_drop_sum;

  function automatic logic [ID_W-1:0] rr_pick(input logic [N_BTN-1:0] req,
                                              input logic [ID_W-1:0]  ptr);
    logic [ID_W-1:0] pick;
    logic            found;
    int unsigned     idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N_BTN; k++) begin
      idx = (32'(ptr) + k) % N_BTN;
      if (!found && req[idx]) begin
        pick  = ID_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign w_cap      = en ? btn_pulse : '0;
  assign w_gnt      = (r_pending != '0) && !w_fifo_full;
  assign w_gnt_id   = rr_pick(r_pending, r_rr_ptr);
  assign w_gnt_vec  = w_gnt ? (N_BTN'(1) << w_gnt_id) : '0;
  // A press on a latch that is being granted this cycle re-arms it instead of dropping.
  assign w_drop_vec = w_cap & r_pending & ~w_gnt_vec;

  always_comb begin
    w_drop_sum = {1'b0, r_drop_cnt};
    for (int unsigned i = 0; i < N_BTN; i++)
      w_drop_sum = w_drop_sum + (DROP_W+1)'(w_drop_vec[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending  <= '0;
      r_rr_ptr   <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_pending  <= (r_pending & ~w_gnt_vec) | w_cap;
      r_drop_cnt <= w_drop_sum[DROP_W] ? '1 : w_drop_sum[DROP_W-1:0];
      if (w_gnt)
        r_rr_ptr <= (w_gnt_id == ID_W'(N_BTN - 1)) ? '0 : w_gnt_id + ID_W'(1);
    end
  end

  key_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ID_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_gnt),
    .i_data  (w_gnt_id),
    .i_pop   (evt_ready),
    .o_data  (evt_id),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign evt_valid = !w_fifo_empty;
  assign fifo_full = w_fifo_full;
  assign pending   = r_pending;
  assign drop_cnt  = r_drop_cnt;
endmodule

// File: tb/tb_key_event_arbiter.sv
// Self-checking bench: vector table plus hand sequences, scoreboard on popped events.
module tb_key_event_arbiter;
  import key_evt_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] btn_pulse = '0;
  logic       evt_valid;
  evt_id_t    evt_id;
  logic       evt_ready = 1'b0;
  logic [3:0] pending;
  logic       fifo_full;
  logic [7:0] drop_cnt;

  int unsigned n_tot  = 0;
  int unsigned n_pass = 0;
  evt_id_t     sb[$];

  key_event_arbiter #(
    .N_BTN      (4),
    .FIFO_DEPTH (4),
    .ID_W       (2),
    .DROP_W     (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .btn_pulse (btn_pulse),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .evt_ready (evt_ready),
    .pending   (pending),
    .fifo_full (fifo_full),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_before;
    logic       en;
    logic [3:0] btn;
    logic       rdy;
    logic       ev;
    logic [1:0] eid;
    logic [3:0] epend;
    logic       efull;
    logic [7:0] edrop;
    int         sbn;
    logic [7:0] sbids;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(input logic r, input logic e, input logic [3:0] b, input logic rd,
                              input logic ev, input logic [1:0] eid, input logic [3:0] ep,
                              input logic ef, input logic [7:0] ed, input int sbn,
                              input logic [7:0] sbids);
    vec_t v;
    v.rst_before = r;  v.en = e;   v.btn = b;    v.rdy = rd;
    v.ev = ev;         v.eid = eid; v.epend = ep; v.efull = ef;
    v.edrop = ed;      v.sbn = sbn; v.sbids = sbids;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    if (evt_valid && evt_ready) begin
      if (sb.size() == 0) begin
        n_tot++;
        $display("FAIL unexpected_evt: got id %0d expected none", evt_id);
      end else begin
        chk("evt_order", 32'(evt_id), 32'(sb.pop_front()));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; btn_pulse = '0; evt_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain(input int unsigned budget);
    btn_pulse = '0;
    evt_ready = 1'b1;
    for (int unsigned c = 0; c < budget && (evt_valid || pending != '0); c++) tick();
    chk("drain_done", {27'd0, evt_valid, pending}, 32'd0);
  endtask

  initial begin
    tbl[0]  = mk(1, 1, 4'b0100, 1, 0, 0, 4'b0100, 0, 0, 1, 8'h02);
    tbl[1]  = mk(0, 1, 4'b0000, 1, 1, 2, 4'b0000, 0, 0, 0, 8'h00);
    tbl[2]  = mk(0, 1, 4'b0000, 1, 0, 0, 4'b0000, 0, 0, 0, 8'h00);
    tbl[3]  = mk(1, 1, 4'b1011, 0, 0, 0, 4'b1011, 0, 0, 3, 8'h34);
    tbl[4]  = mk(0, 1, 4'b0000, 0, 1, 0, 4'b1010, 0, 0, 0, 8'h00);
    tbl[5]  = mk(0, 1, 4'b0000, 0, 1, 0, 4'b1000, 0, 0, 0, 8'h00);
    tbl[6]  = mk(0, 1, 4'b0010, 0, 1, 0, 4'b0010, 0, 0, 1, 8'h01);
    tbl[7]  = mk(0, 1, 4'b0000, 0, 1, 0, 4'b0000, 1, 0, 0, 8'h00);
    tbl[8]  = mk(0, 1, 4'b0010, 0, 1, 0, 4'b0010, 1, 0, 0, 8'h00);
    tbl[9]  = mk(0, 1, 4'b0001, 0, 1, 0, 4'b0011, 1, 0, 2, 8'h04);
    tbl[10] = mk(0, 1, 4'b0001, 0, 1, 0, 4'b0011, 1, 1, 0, 8'h00);
    tbl[11] = mk(0, 1, 4'b0000, 1, 1, 1, 4'b0011, 0, 1, 0, 8'h00);
    tbl[12] = mk(0, 1, 4'b0000, 0, 1, 1, 4'b0010, 1, 1, 0, 8'h00);
    tbl[13] = mk(0, 1, 4'b0000, 1, 1, 3, 4'b0010, 0, 1, 0, 8'h00);
    tbl[14] = mk(0, 1, 4'b0000, 1, 1, 1, 4'b0000, 0, 1, 0, 8'h00);
    tbl[15] = mk(0, 1, 4'b0000, 1, 1, 0, 4'b0000, 0, 1, 0, 8'h00);
    tbl[16] = mk(0, 1, 4'b0000, 1, 1, 1, 4'b0000, 0, 1, 0, 8'h00);
    tbl[17] = mk(0, 1, 4'b0000, 1, 0, 0, 4'b0000, 0, 1, 0, 8'h00);

    do_reset();
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_id", 32'(evt_id), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);

    foreach (tbl[r]) begin
      if (tbl[r].rst_before) do_reset();
      en = tbl[r].en; btn_pulse = tbl[r].btn; evt_ready = tbl[r].rdy;
      for (int k = 0; k < tbl[r].sbn; k++) sb.push_back(tbl[r].sbids[2*k +: 2]);
      tick();
      chk($sformatf("r%0d_valid", r), 32'(evt_valid), 32'(tbl[r].ev));
      if (tbl[r].ev) chk($sformatf("r%0d_id", r), 32'(evt_id), 32'(tbl[r].eid));
      chk($sformatf("r%0d_pending", r), 32'(pending), 32'(tbl[r].epend));
      chk($sformatf("r%0d_full", r), 32'(fifo_full), 32'(tbl[r].efull));
      chk($sformatf("r%0d_drop", r), 32'(drop_cnt), 32'(tbl[r].edrop));
    end
    chk("tbl_sb_empty", sb.size(), 32'd0);

    // Saturation: btn 0 pulsed every cycle with consumer stalled.
    do_reset();
    en = 1'b1; evt_ready = 1'b0; btn_pulse = 4'b0001;
    for (int k = 0; k < 5; k++) sb.push_back(2'd0);
    for (int k = 0; k < 310; k++) begin
      tick();
      if (k == 4) begin
        chk("sat_full", 32'(fifo_full), 32'd1);
        chk("sat_drop4", 32'(drop_cnt), 32'd0);
      end
      if (k == 5)   chk("sat_drop5", 32'(drop_cnt), 32'd1);
      if (k == 258) chk("sat_drop254", 32'(drop_cnt), 32'd254);
      if (k == 259) chk("sat_drop255", 32'(drop_cnt), 32'd255);
      if (k == 309) chk("sat_hold", 32'(drop_cnt), 32'd255);
    end
    chk("sat_pending", 32'(pending), 32'b0001);
    drain(20);
    chk("sat_drop_after", 32'(drop_cnt), 32'd255);
    chk("sat_sb_empty", sb.size(), 32'd0);

    // en=0: pulses ignored, arbitration and draining continue.
    do_reset();
    en = 1'b1; evt_ready = 1'b0; btn_pulse = 4'b0110;
    sb.push_back(2'd1); sb.push_back(2'd2);
    tick();
    btn_pulse = '0;
    tick();
    en = 1'b0; btn_pulse = 4'b1111;
    tick();
    chk("en0_pending", 32'(pending), 32'd0);
    chk("en0_drop", 32'(drop_cnt), 32'd0);
    chk("en0_head", 32'(evt_id), 32'd1);
    evt_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("en0_pend_%0d", k), 32'(pending), 32'd0);
      chk($sformatf("en0_drop_%0d", k), 32'(drop_cnt), 32'd0);
    end
    chk("en0_drained", 32'(evt_valid), 32'd0);
    chk("en0_sb_empty", sb.size(), 32'd0);

    // Async reset mid-cycle with 3 queued events and pending=1010.
    do_reset();
    en = 1'b1; evt_ready = 1'b0; btn_pulse = 4'b0111;
    tick();
    btn_pulse = '0;
    tick();
    tick();
    btn_pulse = 4'b1010;
    tick();
    btn_pulse = 4'b0000;
    chk("ar_pre_pending", 32'(pending), 32'b1010);
    chk("ar_pre_valid", 32'(evt_valid), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_valid", 32'(evt_valid), 32'd0);
    chk("ar_id", 32'(evt_id), 32'd0);
    chk("ar_pending", 32'(pending), 32'd0);
    chk("ar_full", 32'(fifo_full), 32'd0);
    chk("ar_drop", 32'(drop_cnt), 32'd0);
    #2;
    rst = 1'b0;
    evt_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("ar_post_valid_%0d", k), 32'(evt_valid), 32'd0);
      chk($sformatf("ar_post_pend_%0d", k), 32'(pending), 32'd0);
    end

    chk("final_sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/key_event_arbiter.md
Name: key_event_arbiter

Overview:
Collects one-cycle press pulses from N debounced button instances and serialises them into a single ordered event stream for the mode/setting controller. Each button has a pending latch. A round-robin arbiter moves one pending press per cycle into a small event FIFO. The FIFO is drained through a valid/ready handshake. Presses that cannot be held are counted, never silently merged.

Parameters:
N_BTN, 4, number of button pulse inputs (2..8)
FIFO_DEPTH, 4, event FIFO entries (power of 2, >=2)
ID_W, 2, event id width; must equal ceil(log2(N_BTN))
DROP_W, 8, width of saturating dropped-press counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
en  in  1  1 = accept new pulses; 0 = ignore incoming pulses (pending/FIFO keep draining)
btn_pulse  in  N_BTN  one-cycle press pulses, bit i = button i
evt_valid  out  1  FIFO head holds an event
evt_id  out  ID_W  button index of head event (valid only with evt_valid)
evt_ready  in  1  consumer accepts head when evt_valid & evt_ready
pending  out  N_BTN  current pending latches
fifo_full  out  1  FIFO holds FIFO_DEPTH entries
drop_cnt  out  DROP_W  dropped presses, saturating at all-ones

Behaviour:
- Reset (async, rst=1): pending=0, FIFO empty, evt_valid=0, evt_id=0, fifo_full=0, drop_cnt=0, round-robin pointer=0 (button 0 highest priority first). Reset asserted mid-operation discards all pending and queued events immediately.
- Capture: at each edge with en=1, pending[i] is set if btn_pulse[i]=1.
- Grant: combinational from registered pending. Condition: pending != 0 and fifo_full=0. Select the first set bit searching from rr_ptr upward, wrapping from N_BTN-1 to 0. At most one grant per cycle.
- On grant of index g at an edge:
  - push g into the FIFO.
  - clear pending[g], unless btn_pulse[g]=1 with en=1 in the same cycle. In that case pending[g] stays 1 as a new press and no drop is counted.
  - rr_ptr <= (g+1) mod N_BTN.
- No grant: rr_ptr holds.
- Drop: btn_pulse[i]=1 with en=1 while pending[i]=1 and i not granted that cycle. The press is lost and drop_cnt increments by 1, saturating. Multiple simultaneous drops in one cycle add their count, saturating.
- Latency (idle system): pulse sampled at edge E0 gives pending after E0, push at E1, evt_valid=1 after E1. Pulse-to-valid is 2 cycles.
- FIFO:
  - registered, first-in first-out; evt_id is the head entry.
  - pop when evt_valid & evt_ready.
  - Push and pop in the same cycle are both honoured when not full; count is unchanged.
  - When full, no grant occurs, even if a pop happens that cycle. Grant resumes the cycle after fifo_full drops.
  - Pointers wrap modulo FIFO_DEPTH.
  - evt_ready with evt_valid=0 has no effect.
- evt_valid/evt_id must be stable while evt_valid=1 and evt_ready=0.
- en=0: pulses are neither captured nor counted as drops. Arbitration and draining continue.
- Ordering guarantee: events from the same button leave in press order. Across buttons, order follows grant order.

Decomposition:
- Shared package key_evt_pkg: N_BTN, ID_W, DROP_W defaults, FIFO_DEPTH default, and the id type (logic [ID_W-1:0]).
- One sub-module: key_evt_fifo. Parameterised synchronous FIFO with push/pop, data=ID_W, full/empty outputs, async active-high reset.
- Round-robin select stays in key_event_arbiter as a function.

Test Plan:
- Reset, then single pulse on btn 2 at E0, evt_ready=1 -> evt_valid=1 with evt_id=2 exactly after E1, popped after E2. drop_cnt=0, pending=0.
- Pulses on btns 0,1,3 in the same cycle, evt_ready=0 -> FIFO receives 0,1,3 in consecutive cycles. Then pulse on 1 -> order 0,1,3,1, fifo_full=1, next pulse stays pending.
- evt_ready=0, FIFO full, pending[0]=1, second pulse on btn 0 -> drop_cnt=1. Then assert evt_ready -> one pop, btn 0 granted the following cycle.
- 300 repeated overrun pulses on one btn with FIFO full -> drop_cnt saturates at 255, no wrap.
- en=0 with pulses on all btns -> pending unchanged, drop_cnt unchanged. Existing FIFO contents still drain.
- rst asserted asynchronously mid-cycle with FIFO holding 3 events and pending=4'b1010 -> all outputs return to reset values before the next clk edge, and nothing is emitted after release.
